audio_capture: RTL
==================

# audio_capture

Records audio from the CODEC ADC side into a sample RAM. It is the capture-path counterpart of the sample-ROM playback path that feeds `writedata_left`/`writedata_right`. The block drains the CODEC read FIFO, mixes left and right to mono, decimates, and writes 16-bit samples to a single-port RAM. That RAM has the same depth and address width as the playback ROMs, so a recorded clip can later replace a stock sound effect. It sits beside `audio_codec` in the audio top level, sharing `read`, `read_ready`, `readdata_left` and `readdata_right`.

## Interface
Parameters:
- `ADDR_W`, default 15: RAM address width. Depth is 2**ADDR_W samples.
- `DATA_W`, default 16: stored sample width.
- `DECIM`, default 1: keep one of every `DECIM` accepted CODEC samples. Legal range 1..255.

Ports:
- `CLOCK_50`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: reset, synchronous, active-high; clock `CLOCK_50`.
- `start`, in, 1: record request. Level; only its rising edge is acted on.
- `abort`, in, 1: stop capture immediately.
- `read_ready`, in, 1: CODEC has an ADC sample pair available.
- `readdata_left`, in, 24, signed: CODEC left sample.
- `readdata_right`, in, 24, signed: CODEC right sample.
- `read`, out, 1: consume the current CODEC sample pair.
- `mem_addr`, out, `ADDR_W`: RAM write address.
- `mem_wdata`, out, `DATA_W`, signed: RAM write data.
- `mem_we`, out, 1: RAM write enable, one-cycle pulse.
- `busy`, out, 1: capture in progress.
- `done`, out, 1: buffer completely filled.
- `length`, out, `ADDR_W`+1: number of samples written in the last capture.
- `peak`, out, `DATA_W`-1: maximum absolute value of the stored samples in the current or last capture.

## Operation
- `read` = `read_ready` (combinational) in every state, including IDLE and DONE. The CODEC FIFO is always drained, so it never overflows.
- Accept event: a cycle with `read_ready`=1.
- Mixing:
  - mix = (sext25(L) + sext25(R)) >>> 1, with an arithmetic shift.
  - sample = mix[23 -: `DATA_W`], i.e. truncation with no rounding.
- Decimation:
  - `dcnt` counts accept events while in CAPTURE.
  - A sample is stored when `dcnt`==`DECIM`-1; `dcnt` then wraps to 0.
  - `dcnt` clears on entry to CAPTURE.
- FSM states:
  - IDLE → CAPTURE on a rising edge of `start` (`start` & ~`start_q`). Entry clears the write address, `length`, `peak` and `dcnt`.
  - CAPTURE → DONE after the write to address 2**`ADDR_W`-1.
  - CAPTURE → IDLE on `abort`. `length` keeps the count written so far and `done` stays 0.
  - DONE → IDLE when `start`=0. `done` is held until then.
  - A held `start` never retriggers a capture; a new rising edge is required.
- Peak: on each store, if |sample| > `peak` then `peak` <= |sample|. For the most negative sample, |−2**(`DATA_W`-1)| saturates to 2**(`DATA_W`-1)-1.
- Simultaneous events:
  - `abort` and a store in the same cycle: `abort` wins and no write occurs.
  - A rising edge of `start` while in CAPTURE or DONE is ignored.
- Reset values: state IDLE; `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `busy`=0, `done`=0, `length`=0, `peak`=0, `start_q`=0.
- A reset during CAPTURE returns the block to IDLE with no further writes. Any partial RAM contents are left as they are.

## Timing
- Store latency: an accept in cycle n gives `mem_we`=1 in cycle n+1, with `mem_addr` and `mem_wdata` registered to the same cycle.
- `length` and `peak` update in cycle n+1. The address increments after the write.
- `busy` is 1 from the cycle after the `start` edge through the cycle after the final write.
- `done` is asserted in the same cycle as the final `mem_we` deasserts, i.e. in cycle n+2 for a final accept in cycle n.
- Maximum throughput: one store per clock. This is not reachable in practice, since the CODEC rate is 48 kHz against a 50 MHz clock.

## Structure
- Shared package `audio_pkg`:
  - state enum `cap_state_t` (IDLE, CAPTURE, DONE);
  - `AUDIO_W`=24;
  - `SAMPLE_ADDR_W`=15, matching the playback ROM counters.
- Sub-module `sample_mixer`: pure function of L and R giving the mono `sample` and its saturated `abs`. Unit-tested separately.
- The RAM itself is outside this block and is instantiated at the audio top level.

## Test plan
- L=R=24'h100000 on one accept in CAPTURE → `mem_we` one cycle later with `mem_wdata`=16'h1000, `mem_addr`=0, `peak`=0x1000.
- L=24'h800000, R=24'h800000 → `mem_wdata`=16'h8000 and `peak`=0x7FFF (saturated abs).
- `DECIM`=4 with 12 accepts → exactly 3 writes, at addresses 0, 1, 2; `length`=3.
- `ADDR_W`=4 with continuous accepts → 16 writes, then `done`=1 and `busy`=0; further accepts still give `read`=1 and no `mem_we`; `length`=16.
- `abort` asserted on the same cycle as the 5th accept → no 5th write; state IDLE; `length`=4; `done`=0.
- `start` held high through DONE → no second capture; after dropping `start` and raising it again → capture restarts at address 0 with `peak` cleared.
- Reset mid-capture → next cycle all outputs at their reset values, with no `mem_we`.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: CODEC sample width, sample-memory address width
// and the capture FSM state type.
package audio_pkg;
    localparam int AUDIO_W       = 24;
    localparam int SAMPLE_ADDR_W = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;
endpackage

// File: rtl/sample_mixer.sv
// Stereo-to-mono mixer: averages the two CODEC channels, truncates to DATA_W bits
// and also gives the magnitude, saturated so the most negative value still fits.
module sample_mixer
    import audio_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [AUDIO_W-1:0] left,
    input  logic signed [AUDIO_W-1:0] right,
    output logic signed [DATA_W-1:0]  sample,
    output logic        [DATA_W-2:0]  sample_abs
);
    logic signed [AUDIO_W:0] sum_s;
    logic signed [AUDIO_W:0] mix_s;
    logic                    unused_s;

    // Mix, truncate, and take the saturated absolute value.
    always_comb begin
        sum_s  = {left[AUDIO_W-1], left} + {right[AUDIO_W-1], right};
        mix_s  = sum_s >>> 1;
        sample = mix_s[AUDIO_W-1 -: DATA_W];
        if (!sample[DATA_W-1]) begin
            sample_abs = sample[DATA_W-2:0];
        end else if (sample[DATA_W-2:0] == {(DATA_W-1){1'b0}}) begin
            sample_abs = {(DATA_W-1){1'b1}};
        end else begin
            // Only the low bits of the negation are needed once the sign is known.
            sample_abs = ~sample[DATA_W-2:0] + {{(DATA_W-2){1'b0}}, 1'b1};
        end
    end

    // The dropped fraction bits and the redundant sign bit are intentionally discarded.
    assign unused_s = ^{mix_s[AUDIO_W], mix_s[AUDIO_W-DATA_W-1:0]};
endmodule

// File: rtl/audio_capture.sv
// Records mono, decimated CODEC ADC samples into an external sample RAM sized
// like the playback ROMs, tracking the recorded length and peak level.
module audio_capture
    import audio_pkg::*;
#(
    parameter int ADDR_W = SAMPLE_ADDR_W,
    parameter int DATA_W = 16,
    parameter int DECIM  = 1
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      read_ready,
    input  logic signed [AUDIO_W-1:0] readdata_left,
    input  logic signed [AUDIO_W-1:0] readdata_right,
    output logic                      read,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic signed [DATA_W-1:0]  mem_wdata,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W:0]           length,
    output logic [DATA_W-2:0]         peak
);
    localparam logic [7:0]        DCNT_LAST = 8'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    cap_state_t               state_r;
    logic                     start_q_r;
    logic [7:0]               dcnt_r;
    logic signed [DATA_W-1:0] sample_s;
    logic [DATA_W-2:0]        abs_s;
    logic                     start_edge_s;

    sample_mixer #(.DATA_W(DATA_W)) u_mixer (
        .left       (readdata_left),
        .right      (readdata_right),
        .sample     (sample_s),
        .sample_abs (abs_s)
    );

    // The CODEC FIFO is drained in every state so it can never overflow.
    assign read         = read_ready;
    assign start_edge_s = start & ~start_q_r;

    // Capture FSM; length doubles as the write pointer for the next store.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r   <= IDLE;
            start_q_r <= 1'b0;
            dcnt_r    <= 8'd0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            length    <= {(ADDR_W+1){1'b0}};
            peak      <= {(DATA_W-1){1'b0}};
        end else begin
            start_q_r <= start;
            mem_we    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        state_r  <= CAPTURE;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        dcnt_r   <= 8'd0;
                        mem_addr <= {ADDR_W{1'b0}};
                        length   <= {(ADDR_W+1){1'b0}};
                        peak     <= {(DATA_W-1){1'b0}};
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else if (read_ready && (dcnt_r == DCNT_LAST)) begin
                        dcnt_r    <= 8'd0;
                        mem_we    <= 1'b1;
                        mem_addr  <= length[ADDR_W-1:0];
                        mem_wdata <= sample_s;
                        length    <= length + LEN_ONE;
                        if (abs_s > peak) begin
                            peak <= abs_s;
                        end
                        if (length[ADDR_W-1:0] == ADDR_LAST) begin
                            state_r <= DONE;
                        end
                    end else begin
                        if (read_ready) begin
                            dcnt_r <= dcnt_r + 8'd1;
                        end
                        mem_addr <= length[ADDR_W-1:0];
                    end
                end
                DONE: begin
                    // busy drops and done rises one cycle after the final write.
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else if (!start) begin
                        done    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule
